// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two read requesters access to a combinational-read memory.
// Define ARB_FIXED_PRIO_EN so requester 0 wins every tie; the default is round-robin.
module mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
);
    // state  | meaning
    // IDLE   | no access in flight; arbitrate on every edge
    // ACCESS | mem_addr held, wait counter running down to zero
    // RESP   | one-cycle ack for the granted requester

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [3:0]        cnt;
    logic [3:0]        cntNext;
    logic              grant;
    logic              grantNext;
    logic              lastGrant;
    logic              lastGrantNext;
    logic              pick;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] rdataNext;
    logic              ack0Next;
    logic              ack1Next;

`ifdef ARB_FIXED_PRIO_EN
    assign pick = ~req0;
`else
    // On a tie the requester that was not served last goes next.
    assign pick = (req0 && req1) ? ~lastGrant : req1;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            grant     <= 1'b0;
            lastGrant <= 1'b1;
            mem_addr  <= '0;
            rdata     <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            grant     <= grantNext;
            lastGrant <= lastGrantNext;
            mem_addr  <= memAddrNext;
            rdata     <= rdataNext;
            ack0      <= ack0Next;
            ack1      <= ack1Next;
        end
    end

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        grantNext     = grant;
        lastGrantNext = lastGrant;
        memAddrNext   = mem_addr;
        rdataNext     = rdata;
        ack0Next      = 1'b0;
        ack1Next      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grantNext   = pick;
                    memAddrNext = pick ? addr1 : addr0;
                    cntNext     = CNT_LOAD;
                    stateNext   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    rdataNext     = mem_data;
                    ack0Next      = ~grant;
                    ack1Next      = grant;
                    lastGrantNext = grant;
                    stateNext     = RESP;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
